// File: rtl/intr_prio_cfg_seq_pkg.sv
// Shared types and default sizes for the interrupt-controller priority configuration sequencer.
package intr_cfg_pkg;

    localparam int NUM_SRC_DEF = 16;
    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_ACCESS = 3'd2,
        R_SETUP  = 3'd3,
        R_ACCESS = 3'd4,
        DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_WR_TIMEOUT = 2'd1,
        ERR_RD_TIMEOUT = 2'd2,
        ERR_MISMATCH   = 2'd3
    } err_code_e;

endpackage

// File: rtl/intr_prio_cfg_seq_if.sv
// APB link between the configuration sequencer (master) and the interrupt controller (slave).
// Signal suffixes are written from the master's point of view.
interface intr_prio_cfg_seq_if
    import intr_cfg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pwrite_o;
    logic              penable_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;

    modport master (
        output paddr_o,
        output pwdata_o,
        output pwrite_o,
        output penable_o,
        input  prdata_i,
        input  pready_i
    );

    modport slave (
        input  paddr_o,
        input  pwdata_o,
        input  pwrite_o,
        input  penable_o,
        output prdata_i,
        output pready_i
    );

endinterface

// File: rtl/intr_prio_cfg_seq_xfer.sv
// Single APB SETUP/ACCESS transfer engine. The owning FSM says which phase it is in; this block
// drives the bus, watches pready and flags completion or a timeout after TIMEOUT stalled cycles.
module intr_apb_xfer
    import intr_cfg_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                pclk_i,
    input  logic                prst_i,
    input  logic                req_i,
    input  logic                access_i,
    input  logic                write_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                done_o,
    output logic                timeout_o,
    output logic [DATA_W-1:0]   rdata_o,
    intr_prio_cfg_seq_if.master apb
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_q, wait_d;

    // Stall counter: cleared outside ACCESS, counts ACCESS cycles where the slave holds pready low.
    always_comb begin
        wait_d = wait_q;
        if (!access_i) begin
            wait_d = '0;
        end else if (!apb.pready_i) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Bus drive is purely a decode of the current phase so a reset drops penable immediately.
    always_comb begin
        apb.paddr_o   = req_i ? addr_i : '0;
        apb.pwdata_o  = (req_i && write_i) ? wdata_i : '0;
        apb.pwrite_o  = req_i && write_i;
        apb.penable_o = access_i;
    end

    assign done_o    = access_i && apb.pready_i;
    assign timeout_o = access_i && !apb.pready_i && (wait_q == LAST_WAIT);
    assign rdata_o   = apb.prdata_i;

endmodule

// File: rtl/intr_prio_cfg_seq.sv
// Priority configuration sequencer: on start, writes one priority per interrupt source over APB,
// optionally reads them all back to compare, then pulses done and reports any error.
module intr_prio_cfg_seq
    import intr_cfg_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      pclk_i,
    input  logic                      prst_i,
    input  logic                      start_i,
    input  logic                      verify_en_i,
    input  logic [NUM_SRC*DATA_W-1:0] prio_table_i,
    intr_prio_cfg_seq_if.master       apb,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [ADDR_W-1:0]         err_idx_o
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_SRC*DATA_W-1:0] table_q, table_d;
    logic                      verify_q, verify_d;
    logic                      err_q, err_d;
    err_code_e                 err_code_q, err_code_d;
    logic [ADDR_W-1:0]         err_idx_q, err_idx_d;

    logic [DATA_W-1:0] cur_prio;
    logic              xfer_req, xfer_access, xfer_write;
    logic              xfer_done, xfer_timeout;
    logic [DATA_W-1:0] xfer_rdata;

    assign cur_prio    = table_q[idx_q*DATA_W +: DATA_W];
    assign xfer_req    = (state_q == W_SETUP) || (state_q == W_ACCESS) ||
                         (state_q == R_SETUP) || (state_q == R_ACCESS);
    assign xfer_access = (state_q == W_ACCESS) || (state_q == R_ACCESS);
    assign xfer_write  = (state_q == W_SETUP) || (state_q == W_ACCESS);

    intr_apb_xfer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .pclk_i    (pclk_i),
        .prst_i    (prst_i),
        .req_i     (xfer_req),
        .access_i  (xfer_access),
        .write_i   (xfer_write),
        .addr_i    (ADDR_W'(idx_q)),
        .wdata_i   (cur_prio),
        .done_o    (xfer_done),
        .timeout_o (xfer_timeout),
        .rdata_o   (xfer_rdata),
        .apb       (apb)
    );

    // Sequencer next state: walk the index through the write pass, then the optional read pass.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        table_d    = table_q;
        verify_d   = verify_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = W_SETUP;
                    idx_d      = '0;
                    table_d    = prio_table_i;
                    verify_d   = verify_en_i;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    err_idx_d  = '0;
                end
            end
            W_SETUP: state_d = W_ACCESS;
            W_ACCESS: begin
                if (xfer_timeout) begin
                    state_d    = DONE;
                    err_d      = 1'b1;
                    err_code_d = ERR_WR_TIMEOUT;
                    err_idx_d  = ADDR_W'(idx_q);
                end else if (xfer_done) begin
                    if (idx_q != LAST_IDX) begin
                        state_d = W_SETUP;
                        idx_d   = idx_q + 1'b1;
                    end else if (verify_q) begin
                        state_d = R_SETUP;
                        idx_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            R_SETUP: state_d = R_ACCESS;
            R_ACCESS: begin
                if (xfer_timeout) begin
                    state_d    = DONE;
                    err_d      = 1'b1;
                    err_code_d = ERR_RD_TIMEOUT;
                    err_idx_d  = ADDR_W'(idx_q);
                end else if (xfer_done) begin
                    if (xfer_rdata != cur_prio) begin
                        state_d    = DONE;
                        err_d      = 1'b1;
                        err_code_d = ERR_MISMATCH;
                        err_idx_d  = ADDR_W'(idx_q);
                    end else if (idx_q != LAST_IDX) begin
                        state_d = R_SETUP;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, latched configuration and sticky error registers.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            table_q    <= '0;
            verify_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            table_q    <= table_d;
            verify_q   <= verify_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign busy_o     = xfer_req;
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign err_idx_o  = err_idx_q;

endmodule
